output_vc_link_ctrl: RTL and testbench
======================================

# output_vc_link_ctrl

Per-output-port controller for one router port. It holds the two one-entry virtual-channel output buffers (even VC0, odd VC1) that the even and odd switch arbiters write into, and reports their empty status back to the arbiters. It drains the opposite-phase buffer onto the inter-router or PE link with a send/ready handshake. It is instantiated five times per router (UP, DOWN, LEFT, RIGHT, PE) and sits between the switch arbiters and the link wires.

## Interface
- DATA_WIDTH, 64, packet width
- CNT_WIDTH, 16, width of the sent-packet counter

- clk  in  1  router clock, all state on rising edge
- reset  in  1  synchronous, active-high
- polarity  in  1  router phase; 0 = even phase, 1 = odd phase; toggles every cycle
- even_wr_en  in  1  write strobe from even-VC arbiter
- even_wr_data  in  DATA_WIDTH  packet from even-VC arbiter
- odd_wr_en  in  1  write strobe from odd-VC arbiter
- odd_wr_data  in  DATA_WIDTH  packet from odd-VC arbiter
- even_empty  out  1  VC0 buffer empty, to even arbiter
- odd_empty  out  1  VC1 buffer empty, to odd arbiter
- ri  in  1  downstream ready for this port
- so  out  1  send-out strobe, one cycle per packet
- dout  out  DATA_WIDTH  packet on link, valid while so=1
- pkt_count  out  CNT_WIDTH  packets sent since reset
- protocol_err  out  1  sticky error flag

## Operation
- State: full0/buf0 (VC0), full1/buf1 (VC1), so/dout registers, pkt_count, protocol_err.
- Internal/external split by polarity:
  - polarity=0: even arbiter writes VC0; link drains VC1.
  - polarity=1: odd arbiter writes VC1; link drains VC0.
- Write rule at a clock edge:
  - If the phase-matched wr_en=1 and that buffer is empty: latch data, set full.
  - If that buffer is already full: drop the write, keep the old contents, set protocol_err.
- Off-phase write (even_wr_en=1 while polarity=1, or odd_wr_en=1 while polarity=0): ignore it and set protocol_err.
- Send rule at a clock edge, for the link VC L = ~polarity (VC1 when polarity=0, VC0 when polarity=1):
  - If full_L=1 and ri=1: so<=1, dout<=buf_L, full_L<=0, pkt_count<=pkt_count+1.
  - Otherwise: so<=0 and dout holds its last value.
- The written VC and the drained VC always differ in the same cycle, so no read/write collision on one buffer exists.
- pkt_count is unsigned modulo 2^CNT_WIDTH; it wraps from all-ones to 0 with no flag.
- protocol_err clears only on reset.
- Packet contents pass through unmodified; hop and VC fields are the arbiter's responsibility.

## Timing
- Reset values: so=0, dout=0, even_empty=1, odd_empty=1, pkt_count=0, protocol_err=0, both full flags 0.
- Reset mid-operation: buffered packets are discarded and so deasserts on the next cycle.
- even_empty = ~full0 and odd_empty = ~full1. Both are combinational from registered flags, with no dependency on wr_en or ri, so the arbiters see no combinational loop.
- Write-to-link latency:
  - Write accepted at edge k (polarity=0, VC0).
  - Edge k+1 (polarity=1) sends it if ri=1.
  - so=1 and dout valid in the cycle after edge k+1.
  - Minimum 2 cycles from the write strobe to so.
- If ri=0 at the drain edge, the packet stays buffered. The next eligible drain edge for that VC is two cycles later (same polarity).
- Buffer empty-after-send is visible the cycle after the send edge; a new write to that VC is accepted at the next same-phase edge.
- so is a single-cycle pulse per packet; back-to-back cycles may carry VC0 and VC1 packets alternately.
- ri is sampled only at edges; a change mid-cycle has no effect.

## Test plan
- Reset: assert reset for 2 cycles with both wr_en=1 and ri=1 → so=0, dout=0, even_empty=1, odd_empty=1, pkt_count=0, protocol_err=0.
- Basic even path: polarity=0 edge with even_wr_en=1, data=64'h0000_0000_DEAD_BEEF, ri=1 → even_empty=0 next cycle; next edge (polarity=1) → so=1, dout=64'h0000_0000_DEAD_BEEF, pkt_count=1, even_empty=1.
- Backpressure: VC1 holds 64'h8000_0000_0000_0001, ri=0 for 3 polarity=0 edges → so stays 0, odd_empty=0; ri=1 at the next polarity=0 edge → so=1 with that data, pkt_count incremented once.
- Alternating traffic: write both VCs every cycle with distinct data, ri=1 for 20 cycles → so=1 every cycle after the first 2, VC0/VC1 packets alternating in order, no loss, protocol_err=0.
- Protocol errors:
  - even_wr_en=1 while polarity=1 → protocol_err=1, VC0 unchanged.
  - Separately, a second even write while VC0 is full and ri=0 → original data retained and sent later, protocol_err=1.
- Counter wrap: with CNT_WIDTH=4, send 17 packets → pkt_count reads 15 after the 15th packet, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/output_vc_link_ctrl.sv
// output_vc_link_ctrl
// Per-output-port controller. Holds one-entry VC0 (even) and VC1 (odd)
// output buffers. The phase-matched arbiter writes one buffer while the
// opposite-phase buffer drains onto the link with a send/ready handshake.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   polarity              router phase (0 = even: write VC0 / drain VC1)
//   even_wr_en/_data      write port from the even-VC arbiter (VC0)
//   odd_wr_en/_data       write port from the odd-VC arbiter (VC1)
//   even_empty/odd_empty  buffer empty status back to the arbiters
//   ri                    downstream ready
//   so, dout              one-cycle send strobe and registered packet
//   pkt_count             packets sent since reset (wraps)
//   protocol_err          sticky: dropped or off-phase write seen
module output_vc_link_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input  logic                  even_wr_en,
  input  logic [DATA_WIDTH-1:0] even_wr_data,
  input  logic                  odd_wr_en,
  input  logic [DATA_WIDTH-1:0] odd_wr_data,
  output logic                  even_empty,
  output logic                  odd_empty,
  input  logic                  ri,
  output logic                  so,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  protocol_err
);

  logic                  full0_q, full0_d;
  logic                  full1_q, full1_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  so_q, so_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic                  protocol_err_q, protocol_err_d;

  // Next-state: link drain of ~polarity VC, then write of the polarity VC.
  // The two always target different buffers, so their updates never overlap.
  always_comb begin
    full0_d        = full0_q;
    full1_d        = full1_q;
    buf0_d         = buf0_q;
    buf1_d         = buf1_q;
    so_d           = 1'b0;
    dout_d         = dout_q;
    pkt_count_d    = pkt_count_q;
    protocol_err_d = protocol_err_q;

    // Drain
    if (polarity) begin
      if (full0_q && ri) begin
        so_d        = 1'b1;
        dout_d      = buf0_q;
        full0_d     = 1'b0;
        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
      end
    end else begin
      if (full1_q && ri) begin
        so_d        = 1'b1;
        dout_d      = buf1_q;
        full1_d     = 1'b0;
        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
      end
    end

    // Phase-matched write; a write into a full buffer is dropped
    if (!polarity && even_wr_en) begin
      if (!full0_q) begin
        buf0_d  = even_wr_data;
        full0_d = 1'b1;
      end else begin
        protocol_err_d = 1'b1;
      end
    end
    if (polarity && odd_wr_en) begin
      if (!full1_q) begin
        buf1_d  = odd_wr_data;
        full1_d = 1'b1;
      end else begin
        protocol_err_d = 1'b1;
      end
    end

    // Off-phase strobes are ignored but flagged
    if ((polarity && even_wr_en) || (!polarity && odd_wr_en)) begin
      protocol_err_d = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      full0_q        <= 1'b0;
      full1_q        <= 1'b0;
      buf0_q         <= '0;
      buf1_q         <= '0;
      so_q           <= 1'b0;
      dout_q         <= '0;
      pkt_count_q    <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      full0_q        <= full0_d;
      full1_q        <= full1_d;
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
      so_q           <= so_d;
      dout_q         <= dout_d;
      pkt_count_q    <= pkt_count_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Empty flags come only from registered state, never from wr_en or ri
  assign even_empty   = ~full0_q;
  assign odd_empty    = ~full1_q;
  assign so           = so_q;
  assign dout         = dout_q;
  assign pkt_count    = pkt_count_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_output_vc_link_ctrl.sv
// Bench for output_vc_link_ctrl: a table of directed vectors for the basic
// and backpressure paths, then scoreboarded sequences (per-VC expected
// queues) for streaming, protocol errors, mid-run reset and counter wrap.
// A second instance with CNT_WIDTH=4 runs in lockstep for the wrap cases.
module tb_output_vc_link_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        even_wr_en;
  logic [63:0] even_wr_data;
  logic        odd_wr_en;
  logic [63:0] odd_wr_data;
  logic        ri;
  logic        even_empty, odd_empty, so, protocol_err;
  logic [63:0] dout;
  logic [15:0] pkt_count;
  logic        even_empty4, odd_empty4, so4, protocol_err4;
  logic [63:0] dout4;
  logic [3:0]  pkt_count4;

  always #5 clk = ~clk;

  output_vc_link_ctrl #(.DATA_WIDTH(64), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .even_wr_en(even_wr_en), .even_wr_data(even_wr_data),
    .odd_wr_en(odd_wr_en), .odd_wr_data(odd_wr_data),
    .even_empty(even_empty), .odd_empty(odd_empty), .ri(ri),
    .so(so), .dout(dout), .pkt_count(pkt_count), .protocol_err(protocol_err)
  );

  output_vc_link_ctrl #(.DATA_WIDTH(64), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .polarity(polarity),
    .even_wr_en(even_wr_en), .even_wr_data(even_wr_data),
    .odd_wr_en(odd_wr_en), .odd_wr_data(odd_wr_data),
    .even_empty(even_empty4), .odd_empty(odd_empty4), .ri(ri),
    .so(so4), .dout(dout4), .pkt_count(pkt_count4), .protocol_err(protocol_err4)
  );

  typedef struct {
    logic        pol;
    logic        ewr;
    logic [63:0] ed;
    logic        owr;
    logic [63:0] od;
    logic        r;
    logic        so;
    logic [63:0] dout;
    logic        ee;
    logic        oe;
    logic [15:0] cnt;
    logic        err;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        cur_pol;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] mdout;
  logic [15:0] mcount;
  logic        merr;
  logic        last_send;

  localparam logic [63:0] D1 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] D2 = 64'h8000_0000_0000_0001;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboarded cycle: predict drain/accept, clock once, compare everything
  task automatic cycle(input logic ewr, input logic [63:0] ed,
                       input logic owr, input logic [63:0] od, input logic r);
    logic send;
    polarity     = cur_pol;
    even_wr_en   = ewr;
    even_wr_data = ed;
    odd_wr_en    = owr;
    odd_wr_data  = od;
    ri           = r;
    send = 1'b0;
    if (cur_pol) begin
      if (q0.size() > 0 && r) begin send = 1'b1; mdout = q0.pop_front(); end
    end else begin
      if (q1.size() > 0 && r) begin send = 1'b1; mdout = q1.pop_front(); end
    end
    if (send) mcount = mcount + 16'd1;
    if (!cur_pol && ewr) begin
      if (q0.size() == 0) q0.push_back(ed); else merr = 1'b1;
    end
    if (cur_pol && owr) begin
      if (q1.size() == 0) q1.push_back(od); else merr = 1'b1;
    end
    if ((cur_pol && ewr) || (!cur_pol && owr)) merr = 1'b1;
    @(posedge clk); #1;
    chk("so", 128'(so), 128'(send));
    chk("dout", 128'(dout), 128'(mdout));
    chk("even_empty", 128'(even_empty), 128'(q0.size() == 0));
    chk("odd_empty", 128'(odd_empty), 128'(q1.size() == 0));
    chk("pkt_count", 128'(pkt_count), 128'(mcount));
    chk("protocol_err", 128'(protocol_err), 128'(merr));
    chk("dut4_outs", 128'({so4, dout4, even_empty4, odd_empty4, protocol_err4, pkt_count4}),
        128'({send, mdout, q0.size() == 0, q1.size() == 0, merr, mcount[3:0]}));
    last_send = send;
    cur_pol = ~cur_pol;
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 64'h0, 1'b0, 64'h0, r);
  endtask

  // Write the phase-matched VC (only) with distinct data, ri=1
  task automatic stream(input int n, input logic [63:0] tag);
    for (int i = 0; i < n; i++) begin
      cycle(!cur_pol, tag | 64'(i), cur_pol, tag | 64'(i) | 64'h0100_0000_0000_0000, 1'b1);
      if (i >= 1) chk("stream_so_every_cycle", 128'(so), 128'(1));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    even_wr_en = 1'b1; odd_wr_en = 1'b1; ri = 1'b1;
    even_wr_data = 64'hFFFF_0000_FFFF_0000; odd_wr_data = 64'h0000_FFFF_0000_FFFF;
    for (int i = 0; i < 2; i++) begin
      polarity = cur_pol;
      @(posedge clk); #1;
      cur_pol = ~cur_pol;
    end
    chk("rst_so", 128'(so), 128'(0));
    chk("rst_dout", 128'(dout), 128'(0));
    chk("rst_even_empty", 128'(even_empty), 128'(1));
    chk("rst_odd_empty", 128'(odd_empty), 128'(1));
    chk("rst_pkt_count", 128'(pkt_count), 128'(0));
    chk("rst_protocol_err", 128'(protocol_err), 128'(0));
    chk("rst_pkt_count4", 128'(pkt_count4), 128'(0));
    reset = 1'b0;
    even_wr_en = 1'b0; odd_wr_en = 1'b0;
    q0.delete(); q1.delete();
    mdout = '0; mcount = '0; merr = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    reset = 1'b1; polarity = 1'b0; ri = 1'b0;
    even_wr_en = 1'b0; odd_wr_en = 1'b0;
    even_wr_data = '0; odd_wr_data = '0;
    cur_pol = 1'b0; last_send = 1'b0;
    mdout = '0; mcount = '0; merr = 1'b0;

    //          pol  ewr ed  owr od  ri | so dout ee oe cnt err
    tbl[0]  = '{1'b0, 1'b1, D1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, D1, 1'b1, 1'b1, 16'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, D1, 1'b1, 1'b1, 16'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 64'h0, 1'b1, D2, 1'b0, 1'b0, D1, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, D1, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, D1, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, D1, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, D1, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, D1, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, D1, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, D2, 1'b1, 1'b1, 16'd2, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, D2, 1'b1, 1'b1, 16'd2, 1'b0};

    // Reset with both strobes and ri high
    do_reset();

    // Directed vectors: basic even path and VC1 backpressure
    for (int i = 0; i < 12; i++) begin
      polarity = tbl[i].pol; even_wr_en = tbl[i].ewr; even_wr_data = tbl[i].ed;
      odd_wr_en = tbl[i].owr; odd_wr_data = tbl[i].od; ri = tbl[i].r;
      @(posedge clk); #1;
      chk($sformatf("v%0d_so", i), 128'(so), 128'(tbl[i].so));
      chk($sformatf("v%0d_dout", i), 128'(dout), 128'(tbl[i].dout));
      chk($sformatf("v%0d_even_empty", i), 128'(even_empty), 128'(tbl[i].ee));
      chk($sformatf("v%0d_odd_empty", i), 128'(odd_empty), 128'(tbl[i].oe));
      chk($sformatf("v%0d_pkt_count", i), 128'(pkt_count), 128'(tbl[i].cnt));
      chk($sformatf("v%0d_protocol_err", i), 128'(protocol_err), 128'(tbl[i].err));
    end
    cur_pol = 1'b0; mcount = 16'd2; mdout = D2; merr = 1'b0;

    // Alternating traffic on both VCs
    stream(20, 64'hA000_0000_0000_0000);
    chk("stream_no_err", 128'(protocol_err), 128'(0));

    // Off-phase even write while VC0 holds a packet under backpressure
    if (cur_pol) idle(1'b0);
    cycle(1'b1, 64'h1111_2222_3333_4444, 1'b0, 64'h0, 1'b0);
    cycle(1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 64'h0, 1'b0);
    chk("offphase_err", 128'(protocol_err), 128'(1));
    chk("offphase_vc0_kept", 128'(even_empty), 128'(0));
    idle(1'b1);
    idle(1'b1);
    chk("offphase_orig_sent", 128'(dout), 128'(64'h1111_2222_3333_4444));

    // Reset mid-operation with a buffered packet
    if (cur_pol) idle(1'b0);
    cycle(1'b1, 64'h5555_5555_5555_5555, 1'b0, 64'h0, 1'b0);
    do_reset();
    idle(1'b1);
    idle(1'b1);
    chk("post_reset_no_send", 128'(so), 128'(0));

    // Second write into a full VC0 is dropped
    if (cur_pol) idle(1'b0);
    cycle(1'b1, 64'hAAAA_0000_0000_0001, 1'b0, 64'h0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 64'hBBBB_0000_0000_0002, 1'b0, 64'h0, 1'b0);
    chk("overwrite_err", 128'(protocol_err), 128'(1));
    idle(1'b1);
    chk("overwrite_orig_sent", 128'({so, dout}), 128'({1'b1, 64'hAAAA_0000_0000_0001}));

    // Counter wrap on the 4-bit instance
    do_reset();
    if (cur_pol) idle(1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(!cur_pol, 64'hC000_0000_0000_0000 | 64'(i), cur_pol,
            64'hC100_0000_0000_0000 | 64'(i), 1'b1);
      if (last_send && mcount == 16'd15) chk("wrap_15", 128'(pkt_count4), 128'(15));
      if (last_send && mcount == 16'd16) chk("wrap_16", 128'(pkt_count4), 128'(0));
      if (last_send && mcount == 16'd17) chk("wrap_17", 128'(pkt_count4), 128'(1));
    end
    chk("wrap_wide_count", 128'(pkt_count), 128'(19));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
